// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: taken decode, mispredict redirect/flush, and the
// 2-bit saturating branch history table that fetch reads for prediction.
//
// state | meaning
// IDLE  | accepting branches from EX
// FLUSH | squashing IF/ID/EX after a mispredict; EX branches ignored
module branch_ctrl #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        br_valid_i,
    input  logic        is_jump_i,
    input  logic [2:0]  br_funct3_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] target_i,
    input  logic        pred_taken_i,
    input  logic        BrEq_i,
    input  logic        BrLt_i,
    output logic        BrUn_o,
    input  logic [31:0] pc_if_i,
    output logic        pred_taken_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o,
    output logic [15:0] mispredict_cnt_o
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        redirect_q, redirect_d;
    logic        illegal_q, illegal_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] mcnt_q, mcnt_d;
    logic [1:0]  bht_q [BHT_ENTRIES];
    logic [1:0]  bht_d [BHT_ENTRIES];

    logic             taken, illegal_f3, accepted, mispredict;
    logic [IDX_W-1:0] ex_idx, if_idx;
    logic             unused_pc_bits;

    assign ex_idx         = pc_ex_i[IDX_W+1:2];
    assign if_idx         = pc_if_i[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_if_i[31:IDX_W+2], pc_if_i[1:0]};

    assign BrUn_o       = br_funct3_i[1];
    assign pred_taken_o = bht_q[if_idx][1];

    always_comb begin
        taken      = 1'b0;
        illegal_f3 = 1'b0;
        if (is_jump_i) begin
            taken = 1'b1;
        end else begin
            case (br_funct3_i)
                3'b000:         taken = BrEq_i;
                3'b001:         taken = ~BrEq_i;
                3'b100, 3'b110: taken = BrLt_i;
                3'b101, 3'b111: taken = ~BrLt_i;
                default:        illegal_f3 = 1'b1;
            endcase
        end
    end

    assign accepted   = br_valid_i && (state_q == IDLE);
    assign mispredict = accepted && (taken != pred_taken_i);

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_d    = mispredict;
        illegal_d     = accepted && illegal_f3;
        redirect_pc_d = redirect_pc_q;
        mcnt_d        = mcnt_q;
        bht_d         = bht_q;

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q == 3'd0) state_d = IDLE;
                else                fcnt_d  = fcnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase

        if (mispredict) begin
            redirect_pc_d = taken ? target_i : pc_ex_i + 32'd4;
            mcnt_d        = mcnt_q + 16'd1;
        end

        // Jumps and illegal encodings carry no conditional history.
        if (accepted && !is_jump_i && !illegal_f3) begin
            if (taken && bht_q[ex_idx] != 2'b11)
                bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            else if (!taken && bht_q[ex_idx] != 2'b00)
                bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fcnt_q        <= 3'd0;
            redirect_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= 32'd0;
            mcnt_q        <= 16'd0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redirect_q    <= redirect_d;
            illegal_q     <= illegal_d;
            redirect_pc_q <= redirect_pc_d;
            mcnt_q        <= mcnt_d;
            bht_q         <= bht_d;
        end
    end

    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign illegal_o        = illegal_q;
    assign flush_o          = (state_q == FLUSH);
    assign mispredict_cnt_o = mcnt_q;
endmodule
